// File: rtl/vol_step_sequencer.sv
// ============================================================================
// vol_step_sequencer : press/hold/auto-repeat volume stepper with ack handshake
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module vol_step_sequencer #(
   parameter int VOL_MAX       = 31,
   parameter int VOL_INIT      = 20,
   parameter int HOLD_DELAY    = 12500000,
   parameter int REPEAT_PERIOD = 2500000
) (
   input  logic       i_clk,
   input  logic       reset_n,
   input  logic       btn_minus_i,
   input  logic       btn_plus_i,
   input  logic       upd_ack_i,
   output logic [4:0] vol_o,
   output logic       upd_req_o,
   output logic       limit_o
);

   localparam int C_TMAX  = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
   localparam int C_TMR_W = (C_TMAX > 1) ? $clog2(C_TMAX) : 1;

   localparam logic [C_TMR_W-1:0] C_HOLD_LOAD = C_TMR_W'(HOLD_DELAY - 1);
   localparam logic [C_TMR_W-1:0] C_REP_LOAD  = C_TMR_W'(REPEAT_PERIOD - 1);
   localparam logic [C_TMR_W-1:0] C_TMR_ONE   = C_TMR_W'(1);
   localparam logic [4:0]         C_VOL_MAX   = 5'(VOL_MAX);
   localparam logic [4:0]         C_VOL_INIT  = 5'(VOL_INIT);
   localparam logic [4:0]         C_VOL_ONE   = 5'd1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_HOLD   = 2'd1,
      S_REPEAT = 2'd2,
      S_LOCK   = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [C_TMR_W-1:0]   timer_q, timer_d;
   logic                 dir_q, dir_d;      // 1 = up, 0 = down
   logic [4:0]           vol_q, vol_d;
   logic                 upd_req_q, upd_req_d;
   logic                 limit_q, limit_d;

   logic w_plus;
   logic w_minus;
   logic w_held;
   logic w_step;
   logic w_step_up;
   logic w_change;

   // Buttons are active-low
   assign w_plus  = ~btn_plus_i;
   assign w_minus = ~btn_minus_i;
   assign w_held  = dir_q ? w_plus : w_minus;

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      dir_d     = dir_q;
      w_step    = 1'b0;
      w_step_up = dir_q;
      if (w_plus && w_minus) begin
         state_d = S_LOCK;
         timer_d = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (w_plus || w_minus) begin
                  w_step    = 1'b1;
                  w_step_up = w_plus;
                  dir_d     = w_plus;
                  timer_d   = C_HOLD_LOAD;
                  state_d   = S_HOLD;
               end
            end
            S_HOLD, S_REPEAT: begin
               if (!w_held) begin
                  state_d = S_IDLE;
                  timer_d = '0;
               end else if (timer_q == '0) begin
                  w_step  = 1'b1;
                  timer_d = C_REP_LOAD;
                  state_d = S_REPEAT;
               end else begin
                  timer_d = timer_q - C_TMR_ONE;
               end
            end
            S_LOCK: begin
               if (!w_plus && !w_minus) begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
               timer_d = '0;
            end
         endcase
      end
   end

   // Saturating step; a rejected step pulses limit and never raises a request
   always_comb begin
      vol_d    = vol_q;
      limit_d  = 1'b0;
      w_change = 1'b0;
      if (w_step) begin
         if (w_step_up) begin
            if (vol_q >= C_VOL_MAX) begin
               limit_d = 1'b1;
            end else begin
               vol_d    = vol_q + C_VOL_ONE;
               w_change = 1'b1;
            end
         end else begin
            if (vol_q == '0) begin
               limit_d = 1'b1;
            end else begin
               vol_d    = vol_q - C_VOL_ONE;
               w_change = 1'b1;
            end
         end
      end
      upd_req_d = w_change | (upd_req_q & ~upd_ack_i);
   end

   always_ff @(posedge i_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         timer_q   <= '0;
         dir_q     <= 1'b1;
         vol_q     <= C_VOL_INIT;
         upd_req_q <= 1'b0;
         limit_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         dir_q     <= dir_d;
         vol_q     <= vol_d;
         upd_req_q <= upd_req_d;
         limit_q   <= limit_d;
      end
   end

   assign vol_o     = vol_q;
   assign upd_req_o = upd_req_q;
   assign limit_o   = limit_q;

endmodule

`default_nettype wire

// File: tb/tb_vol_step_sequencer.sv
// ============================================================================
// tb_vol_step_sequencer : directed + randomized bench against a press-count model
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_vol_step_sequencer;

   localparam int P_VMAX  = 31;
   localparam int P_VINIT = 20;
   localparam int P_HOLD  = 8;
   localparam int P_REP   = 4;

   logic       i_clk       = 1'b0;
   logic       reset_n     = 1'b0;
   logic       btn_minus_i = 1'b1;
   logic       btn_plus_i  = 1'b1;
   logic       upd_ack_i   = 1'b0;
   logic [4:0] vol_o;
   logic       upd_req_o;
   logic       limit_o;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: how long the latched button has been held decides steps
   int m_vol;
   bit m_req;
   bit m_lim;
   bit m_active;
   bit m_dir_up;
   bit m_locked;
   int m_cnt;

   vol_step_sequencer #(
      .VOL_MAX       (P_VMAX),
      .VOL_INIT      (P_VINIT),
      .HOLD_DELAY    (P_HOLD),
      .REPEAT_PERIOD (P_REP)
   ) u_dut (
      .i_clk       (i_clk),
      .reset_n     (reset_n),
      .btn_minus_i (btn_minus_i),
      .btn_plus_i  (btn_plus_i),
      .upd_ack_i   (upd_ack_i),
      .vol_o       (vol_o),
      .upd_req_o   (upd_req_o),
      .limit_o     (limit_o)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_vol    = P_VINIT;
      m_req    = 1'b0;
      m_lim    = 1'b0;
      m_active = 1'b0;
      m_dir_up = 1'b1;
      m_locked = 1'b0;
      m_cnt    = 0;
   endtask

   task automatic model_edge();
      bit p, m, do_step, chg;
      p       = !btn_plus_i;
      m       = !btn_minus_i;
      do_step = 1'b0;
      chg     = 1'b0;
      if (p && m) begin
         m_locked = 1'b1;
         m_active = 1'b0;
      end else if (m_locked) begin
         if (!p && !m) m_locked = 1'b0;
      end else if (m_active) begin
         if ((m_dir_up && p) || (!m_dir_up && m)) begin
            m_cnt++;
            if (m_cnt == P_HOLD || (m_cnt > P_HOLD && (m_cnt - P_HOLD) % P_REP == 0))
               do_step = 1'b1;
         end else begin
            m_active = 1'b0;
         end
      end else if (p || m) begin
         m_active = 1'b1;
         m_dir_up = p;
         m_cnt    = 0;
         do_step  = 1'b1;
      end
      m_lim = 1'b0;
      if (do_step) begin
         if (m_dir_up) begin
            if (m_vol == P_VMAX) m_lim = 1'b1;
            else begin m_vol++; chg = 1'b1; end
         end else begin
            if (m_vol == 0) m_lim = 1'b1;
            else begin m_vol--; chg = 1'b1; end
         end
      end
      if (chg) m_req = 1'b1;
      else if (upd_ack_i) m_req = 1'b0;
   endtask

   task automatic check_model(input string tag);
      check({tag, ".vol"},     int'(vol_o),     m_vol);
      check({tag, ".upd_req"}, int'(upd_req_o), int'(m_req));
      check({tag, ".limit"},   int'(limit_o),   int'(m_lim));
   endtask

   task automatic tick(input string tag);
      @(posedge i_clk);
      if (reset_n) model_edge();
      #1;
      check_model(tag);
   endtask

   task automatic drive(input bit p, input bit m, input bit a);
      btn_plus_i  = !p;
      btn_minus_i = !m;
      upd_ack_i   = a;
   endtask

   task automatic run(input string tag, input bit p, input bit m, input int n);
      for (int i = 0; i < n; i++) begin
         drive(p, m, 1'b0);
         tick(tag);
      end
   endtask

   // Asserts reset mid-cycle, holds it across two edges, releases away from an edge
   task automatic do_reset(input string tag);
      reset_n = 1'b0;
      #1;
      model_reset();
      check({tag, ".rst_vol"},   int'(vol_o),     P_VINIT);
      check({tag, ".rst_req"},   int'(upd_req_o), 0);
      check({tag, ".rst_limit"}, int'(limit_o),   0);
      tick(tag);
      tick(tag);
      reset_n = 1'b1;
   endtask

   initial begin
      int kind, len;
      bit p, m;
      model_reset();
      repeat (3) @(posedge i_clk);
      #1;
      check("reset.vol",   int'(vol_o),     P_VINIT);
      check("reset.req",   int'(upd_req_o), 0);
      check("reset.limit", int'(limit_o),   0);
      reset_n = 1'b1;
      run("idle", 1'b0, 1'b0, 2);

      // Single tap, then ack
      drive(1'b1, 1'b0, 1'b0);
      tick("tap");
      check("tap.vol21", int'(vol_o), 21);
      check("tap.req1",  int'(upd_req_o), 1);
      run("tap", 1'b1, 1'b0, 2);
      run("tap", 1'b0, 1'b0, 1);
      drive(1'b0, 1'b0, 1'b1);
      tick("ack");
      check("ack.req0", int'(upd_req_o), 0);
      run("ack", 1'b0, 1'b0, 1);

      // Hold minus 20 cycles from VOL_INIT
      do_reset("r1");
      run("hold", 1'b0, 1'b1, 20);
      check("hold.vol16", int'(vol_o), 16);
      check("hold.req1",  int'(upd_req_o), 1);
      run("hold", 1'b0, 1'b0, 2);

      // Drive to the top and tap into saturation
      run("climb", 1'b1, 1'b0, 64);
      run("climb", 1'b0, 1'b0, 1);
      drive(1'b0, 1'b0, 1'b1);
      tick("climb");
      check("climb.vol31", int'(vol_o), 31);
      drive(1'b1, 1'b0, 1'b0);
      tick("sat");
      check("sat.vol",   int'(vol_o),     31);
      check("sat.limit", int'(limit_o),   1);
      check("sat.req",   int'(upd_req_o), 0);
      tick("sat");
      check("sat.pulse", int'(limit_o), 0);
      run("sat", 1'b1, 1'b0, 1);
      run("sat", 1'b0, 1'b0, 2);

      // Lock on both buttons
      do_reset("r2");
      run("lock", 1'b1, 1'b1, 2);
      run("lock", 1'b0, 1'b1, 5);
      check("lock.vol", int'(vol_o), P_VINIT);
      run("lock", 1'b0, 1'b0, 2);
      drive(1'b1, 1'b0, 1'b0);
      tick("unlock");
      check("unlock.vol21", int'(vol_o), 21);

      // Ack colliding with a repeat step
      for (int i = 0; i < 14; i++) begin
         drive(1'b1, 1'b0, (i == 4) || (i == 7));
         tick("coll");
         if (i == 4) check("coll.cleared", int'(upd_req_o), 0);
         if (i == 7) check("coll.kept",    int'(upd_req_o), 1);
      end
      run("coll", 1'b0, 1'b0, 1);
      drive(1'b0, 1'b0, 1'b1);
      tick("coll2");
      check("coll2.req0", int'(upd_req_o), 0);
      run("coll2", 1'b0, 1'b0, 1);

      // Reset during repeat at 25, button still held across release
      do_reset("r3");
      run("rep", 1'b1, 1'b0, 22);
      check("rep.vol25", int'(vol_o), 25);
      do_reset("rrep");
      drive(1'b1, 1'b0, 1'b0);
      tick("rrep");
      check("rrep.vol21", int'(vol_o), 21);
      run("rrep", 1'b0, 1'b0, 2);

      // Randomized segments
      for (int seg = 0; seg < 300; seg++) begin
         kind = $urandom_range(0, 9);
         len  = $urandom_range(1, 30);
         p    = (kind <= 3) || (kind == 8);
         m    = ((kind >= 4) && (kind <= 7)) || (kind == 8);
         for (int i = 0; i < len; i++) begin
            if (kind == 8 && i == len / 2) begin
               if ($urandom_range(0, 1) == 0) p = 1'b0;
               else m = 1'b0;
            end
            drive(p, m, $urandom_range(0, 3) == 0);
            tick("rand");
         end
         if ($urandom_range(0, 39) == 0) do_reset("rrand");
         if ($urandom_range(0, 2) == 0) begin
            drive(1'b0, 1'b0, $urandom_range(0, 1) == 1);
            tick("rand_gap");
         end
      end

      drive(1'b0, 1'b0, 1'b0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
